// File: rtl/sd_cmd_responder.sv
// sd_cmd_responder
// Card-side responder for the SD CMD line. It receives 48-bit host commands,
// checks their CRC7 and reports the decoded fields to card logic. After NCR
// sdio_clk rising edges it can drive a 48-bit R1 response back on the line.
//
// Ports
//   clk            system clock, at least 4x sdio_clk
//   reset          synchronous active-high reset
//   sdio_clk       host bus clock, asynchronous to clk
//   sdio_cmd_in    CMD pad input
//   sdio_cmd_out   CMD pad output value (1 whenever not driving)
//   sdio_cmd_oe    CMD pad output enable, high only while a response is sent
//   resp_enable    send a response when a good command completes
//   resp_status    32-bit R1 payload, latched when the command completes
//   cmd_valid      one-clk pulse per received frame
//   cmd_index      command index of the last frame
//   cmd_arg        argument of the last frame
//   cmd_ok         last frame had good CRC7, transmission bit 1 and end bit 1
module sd_cmd_responder #(
    parameter int NCR = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sdio_clk,
    input  logic        sdio_cmd_in,
    output logic        sdio_cmd_out,
    output logic        sdio_cmd_oe,
    input  logic        resp_enable,
    input  logic [31:0] resp_status,
    output logic        cmd_valid,
    output logic [5:0]  cmd_index,
    output logic [31:0] cmd_arg,
    output logic        cmd_ok
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_WAIT = 2'd2,
        ST_SEND = 2'd3
    } state_t;

    // One CRC7 step (x^7 + x^3 + 1), MSB-first serial form.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = crc[6] ^ din;
        crc7_step = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    // CRC7 over the 40 leading bits of a frame, starting from zero.
    function automatic logic [6:0] crc7_40(input logic [39:0] data);
        logic [6:0] crc;
        crc = 7'h00;
        for (int i = 39; i >= 0; i--) begin
            crc = crc7_step(crc, data[i]);
        end
        crc7_40 = crc;
    endfunction

    // Synchronizer and history flops; cmd goes through the same depth so the
    // sampled data bit lines up with the detected sdio_clk edge.
    logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic cmd_meta_q, cmd_sync_q;
    logic sclk_rise_s, sclk_fall_s;

    state_t      state_q, state_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [45:0] rx_sr_q, rx_sr_d;
    logic [6:0]  crc_q, crc_d;
    logic [6:0]  wait_cnt_q, wait_cnt_d;
    logic [47:0] tx_sr_q, tx_sr_d;
    logic        cmd_out_q, cmd_out_d;
    logic        cmd_oe_q, cmd_oe_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic [5:0]  cmd_index_q, cmd_index_d;
    logic [31:0] cmd_arg_q, cmd_arg_d;
    logic        cmd_ok_q, cmd_ok_d;

    logic        frame_ok_s;
    logic [5:0]  rx_index_s;
    logic [31:0] rx_arg_s;
    logic [6:0]  rx_crc_s;
    logic [6:0]  resp_crc_s;

    assign sclk_rise_s = sclk_sync_q & ~sclk_prev_q;
    assign sclk_fall_s = ~sclk_sync_q & sclk_prev_q;

    // Field view of the receive shift register: it holds frame bits 46..1
    // when the end bit arrives.
    assign rx_index_s = rx_sr_q[44:39];
    assign rx_arg_s   = rx_sr_q[38:7];
    assign rx_crc_s   = rx_sr_q[6:0];
    assign frame_ok_s = rx_sr_q[45] & cmd_sync_q & (rx_crc_s == crc_q);
    assign resp_crc_s = crc7_40({2'b00, rx_index_s, resp_status});

    assign sdio_cmd_out = cmd_out_q;
    assign sdio_cmd_oe  = cmd_oe_q;
    assign cmd_valid    = cmd_valid_q;
    assign cmd_index    = cmd_index_q;
    assign cmd_arg      = cmd_arg_q;
    assign cmd_ok       = cmd_ok_q;

    // Synchronizers and all FSM/datapath state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_meta_q <= 1'b0;
            sclk_sync_q <= 1'b0;
            sclk_prev_q <= 1'b0;
            cmd_meta_q  <= 1'b1;
            cmd_sync_q  <= 1'b1;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 6'd0;
            rx_sr_q     <= 46'd0;
            crc_q       <= 7'd0;
            wait_cnt_q  <= 7'd0;
            tx_sr_q     <= 48'd0;
            cmd_out_q   <= 1'b1;
            cmd_oe_q    <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_index_q <= 6'd0;
            cmd_arg_q   <= 32'd0;
            cmd_ok_q    <= 1'b0;
        end else begin
            sclk_meta_q <= sdio_clk;
            sclk_sync_q <= sclk_meta_q;
            sclk_prev_q <= sclk_sync_q;
            cmd_meta_q  <= sdio_cmd_in;
            cmd_sync_q  <= cmd_meta_q;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_sr_q     <= rx_sr_d;
            crc_q       <= crc_d;
            wait_cnt_q  <= wait_cnt_d;
            tx_sr_q     <= tx_sr_d;
            cmd_out_q   <= cmd_out_d;
            cmd_oe_q    <= cmd_oe_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_index_q <= cmd_index_d;
            cmd_arg_q   <= cmd_arg_d;
            cmd_ok_q    <= cmd_ok_d;
        end
    end

    // Next-state and output logic for the receive / wait / send sequence.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_sr_d     = rx_sr_q;
        crc_d       = crc_q;
        wait_cnt_d  = wait_cnt_q;
        tx_sr_d     = tx_sr_q;
        cmd_out_d   = cmd_out_q;
        cmd_oe_d    = cmd_oe_q;
        cmd_valid_d = 1'b0;
        cmd_index_d = cmd_index_q;
        cmd_arg_d   = cmd_arg_q;
        cmd_ok_d    = cmd_ok_q;

        case (state_q)
            ST_IDLE: begin
                cmd_oe_d  = 1'b0;
                cmd_out_d = 1'b1;
                if (sclk_rise_s && !cmd_sync_q) begin
                    // The start bit is 0, so it leaves the zero CRC seed unchanged.
                    state_d   = ST_RECV;
                    bit_cnt_d = 6'd46;
                    crc_d     = 7'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_RECV: begin
                if (sclk_rise_s) begin
                    if (bit_cnt_q != 6'd0) begin
                        rx_sr_d   = {rx_sr_q[44:0], cmd_sync_q};
                        bit_cnt_d = bit_cnt_q - 6'd1;
                        // Bits 46..8 are covered by the CRC; bits 7..1 are the CRC itself.
                        if (bit_cnt_q >= 6'd8) begin
                            crc_d = crc7_step(crc_q, cmd_sync_q);
                        end else begin
                            crc_d = crc_q;
                        end
                    end else begin
                        // End bit sampled: publish the frame and prepare the response.
                        cmd_valid_d = 1'b1;
                        cmd_index_d = rx_index_s;
                        cmd_arg_d   = rx_arg_s;
                        cmd_ok_d    = frame_ok_s;
                        tx_sr_d     = {2'b00, rx_index_s, resp_status, resp_crc_s, 1'b1};
                        wait_cnt_d  = 7'd0;
                        if (frame_ok_s && resp_enable) begin
                            state_d = ST_WAIT;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end else begin
                    state_d = ST_RECV;
                end
            end

            ST_WAIT: begin
                if (sclk_rise_s && (wait_cnt_q < 7'(NCR))) begin
                    wait_cnt_d = wait_cnt_q + 7'd1;
                end else if (sclk_fall_s && (wait_cnt_q == 7'(NCR))) begin
                    // Start bit goes out on the same fall that enters SEND.
                    state_d   = ST_SEND;
                    cmd_oe_d  = 1'b1;
                    cmd_out_d = tx_sr_q[47];
                    tx_sr_d   = {tx_sr_q[46:0], 1'b0};
                    bit_cnt_d = 6'd47;
                end else begin
                    state_d = ST_WAIT;
                end
            end

            ST_SEND: begin
                if (sclk_fall_s) begin
                    if (bit_cnt_q == 6'd0) begin
                        state_d   = ST_IDLE;
                        cmd_oe_d  = 1'b0;
                        cmd_out_d = 1'b1;
                    end else begin
                        cmd_out_d = tx_sr_q[47];
                        tx_sr_d   = {tx_sr_q[46:0], 1'b0};
                        bit_cnt_d = bit_cnt_q - 6'd1;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                cmd_oe_d  = 1'b0;
                cmd_out_d = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_sd_cmd_responder.sv
// Directed testbench for sd_cmd_responder: plays the host side of the CMD line
// and checks decoded commands and R1 responses against hand-computed frames.
module tb_sd_cmd_responder;

    logic        clk;
    logic        reset;
    logic        sdio_clk;
    logic        sdio_cmd_in;
    logic        sdio_cmd_out;
    logic        sdio_cmd_oe;
    logic        resp_enable;
    logic [31:0] resp_status;
    logic        cmd_valid;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        cmd_ok;

    int tests_run;
    int tests_failed;

    int          valid_cnt;
    int          oe_cnt;
    logic [5:0]  last_idx;
    logic [31:0] last_arg;
    logic        last_ok;

    sd_cmd_responder dut (
        .clk          (clk),
        .reset        (reset),
        .sdio_clk     (sdio_clk),
        .sdio_cmd_in  (sdio_cmd_in),
        .sdio_cmd_out (sdio_cmd_out),
        .sdio_cmd_oe  (sdio_cmd_oe),
        .resp_enable  (resp_enable),
        .resp_status  (resp_status),
        .cmd_valid    (cmd_valid),
        .cmd_index    (cmd_index),
        .cmd_arg      (cmd_arg),
        .cmd_ok       (cmd_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial sdio_clk = 1'b0;
    always #50 sdio_clk = ~sdio_clk;

    // Monitor: count valid pulses and driven cycles, keep last decoded fields.
    initial begin
        valid_cnt = 0;
        oe_cnt    = 0;
        last_idx  = 6'd0;
        last_arg  = 32'd0;
        last_ok   = 1'b0;
    end
    always @(negedge clk) begin
        if (cmd_valid) begin
            valid_cnt = valid_cnt + 1;
            last_idx  = cmd_index;
            last_arg  = cmd_arg;
            last_ok   = cmd_ok;
        end
        if (sdio_cmd_oe) oe_cnt = oe_cnt + 1;
    end

    // Host drives each bit on the falling edge; returns at the fall after the end bit.
    task automatic send_frame(input logic [47:0] f);
        for (int i = 47; i >= 0; i--) begin
            @(negedge sdio_clk);
            sdio_cmd_in = f[i];
        end
        @(negedge sdio_clk);
        sdio_cmd_in = 1'b1;
    endtask

    task automatic idle_periods(input int n);
        for (int i = 0; i < n; i++) @(posedge sdio_clk);
    endtask

    // Called right after send_frame: checks the NCR gap, the 48 driven bits and release.
    task automatic check_response(input logic [47:0] exp, input string name);
        logic [47:0] got;
        logic        gap_ok;
        logic        oe_held;
        gap_ok  = 1'b1;
        oe_held = 1'b1;
        got     = 48'd0;
        for (int i = 0; i < 2; i++) begin
            @(posedge sdio_clk); #1;
            if (sdio_cmd_oe !== 1'b0) gap_ok = 1'b0;
        end
        tests_run++;
        if (gap_ok !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_ncr_gap: oe rose before rising edge 3 of the gap", name);
        end
        for (int i = 47; i >= 0; i--) begin
            @(posedge sdio_clk); #1;
            if (sdio_cmd_oe !== 1'b1) oe_held = 1'b0;
            got[i] = sdio_cmd_out;
        end
        tests_run++;
        if (oe_held !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_oe_48: oe not high for all 48 bit periods", name);
        end
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s_resp: got %h expected %h", name, got, exp);
        end
        @(posedge sdio_clk); #1;
        tests_run++;
        if (sdio_cmd_oe !== 1'b0 || sdio_cmd_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_release: oe=%b out=%b expected oe=0 out=1", name, sdio_cmd_oe, sdio_cmd_out);
        end
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        sdio_cmd_in = 1'b1;
        resp_enable = 1'b0;
        resp_status = 32'd0;
        repeat (6) @(posedge clk);
        #1;
        tests_run++;
        if (sdio_cmd_oe !== 1'b0 || sdio_cmd_out !== 1'b1 || cmd_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_pad: oe=%b out=%b valid=%b expected 0 1 0", sdio_cmd_oe, sdio_cmd_out, cmd_valid);
        end
        tests_run++;
        if (cmd_index !== 6'd0 || cmd_arg !== 32'd0 || cmd_ok !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_fields: idx=%0d arg=%h ok=%b expected 0 0 0", cmd_index, cmd_arg, cmd_ok);
        end
        @(negedge clk);
        reset = 1'b0;
        idle_periods(4);
    endtask

    task automatic test_cmd0_no_resp();
        int v0, o0;
        v0 = valid_cnt;
        o0 = oe_cnt;
        resp_enable = 1'b0;
        send_frame(48'h40_00000000_95);
        idle_periods(8);
        tests_run++;
        if (valid_cnt - v0 !== 1 || last_idx !== 6'd0 || last_arg !== 32'h0 || last_ok !== 1'b1) begin
            tests_failed++;
            $display("FAIL cmd0_decode: pulses=%0d idx=%0d arg=%h ok=%b expected 1 0 0 1",
                     valid_cnt - v0, last_idx, last_arg, last_ok);
        end
        tests_run++;
        if (oe_cnt - o0 !== 0) begin
            tests_failed++;
            $display("FAIL cmd0_no_oe: oe high for %0d clks expected 0", oe_cnt - o0);
        end
    endtask

    task automatic test_cmd8_resp();
        resp_enable = 1'b1;
        resp_status = 32'h0000_01AA;
        send_frame(48'h48_000001AA_87);
        tests_run++;
        if (last_idx !== 6'd8 || last_arg !== 32'h0000_01AA || last_ok !== 1'b1) begin
            tests_failed++;
            $display("FAIL cmd8_decode: idx=%0d arg=%h ok=%b expected 8 000001aa 1", last_idx, last_arg, last_ok);
        end
        check_response(48'h08_000001AA_13, "cmd8");
        idle_periods(4);
    endtask

    task automatic test_cmd55_resp();
        resp_enable = 1'b1;
        resp_status = 32'h0000_0120;
        send_frame(48'h77_00000000_65);
        tests_run++;
        if (last_idx !== 6'd55 || last_ok !== 1'b1) begin
            tests_failed++;
            $display("FAIL cmd55_decode: idx=%0d ok=%b expected 55 1", last_idx, last_ok);
        end
        check_response(48'h37_00000120_83, "cmd55");
        idle_periods(4);
    endtask

    task automatic test_bad_crc();
        int v0, o0;
        v0 = valid_cnt;
        o0 = oe_cnt;
        resp_enable = 1'b1;
        send_frame(48'h40_00000000_97);
        idle_periods(10);
        tests_run++;
        if (valid_cnt - v0 !== 1 || last_ok !== 1'b0 || last_idx !== 6'd0) begin
            tests_failed++;
            $display("FAIL badcrc_decode: pulses=%0d ok=%b idx=%0d expected 1 0 0", valid_cnt - v0, last_ok, last_idx);
        end
        tests_run++;
        if (oe_cnt - o0 !== 0) begin
            tests_failed++;
            $display("FAIL badcrc_no_resp: oe high for %0d clks expected 0", oe_cnt - o0);
        end
        resp_enable = 1'b0;
        send_frame(48'h40_00000000_95);
        idle_periods(4);
        tests_run++;
        if (valid_cnt - v0 !== 2 || last_ok !== 1'b1) begin
            tests_failed++;
            $display("FAIL badcrc_recover: pulses=%0d ok=%b expected 2 1", valid_cnt - v0, last_ok);
        end
    endtask

    task automatic test_reset_mid_send();
        resp_enable = 1'b1;
        resp_status = 32'h0000_01AA;
        send_frame(48'h48_000001AA_87);
        idle_periods(2 + 20);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (sdio_cmd_oe !== 1'b0 || sdio_cmd_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL midreset_pad: oe=%b out=%b expected 0 1", sdio_cmd_oe, sdio_cmd_out);
        end
        @(negedge clk);
        reset = 1'b0;
        idle_periods(4);
        resp_enable = 1'b0;
        send_frame(48'h48_000001AA_87);
        idle_periods(2);
        tests_run++;
        if (last_idx !== 6'd8 || last_arg !== 32'h0000_01AA || last_ok !== 1'b1) begin
            tests_failed++;
            $display("FAIL midreset_next_cmd8: idx=%0d arg=%h ok=%b expected 8 000001aa 1", last_idx, last_arg, last_ok);
        end
    endtask

    task automatic test_back_to_back();
        int v0;
        v0 = valid_cnt;
        resp_enable = 1'b0;
        send_frame(48'h40_00000000_95);
        tests_run++;
        if (valid_cnt - v0 !== 1 || last_idx !== 6'd0 || last_ok !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_first: pulses=%0d idx=%0d ok=%b expected 1 0 1", valid_cnt - v0, last_idx, last_ok);
        end
        // send_frame already idled one period after the end bit.
        for (int i = 0; i < 7; i++) @(negedge sdio_clk);
        send_frame(48'h77_00000000_65);
        idle_periods(10);
        tests_run++;
        if (valid_cnt - v0 !== 2 || last_idx !== 6'd55 || last_arg !== 32'h0 || last_ok !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_second: pulses=%0d idx=%0d arg=%h ok=%b expected 2 55 0 1",
                     valid_cnt - v0, last_idx, last_arg, last_ok);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_cmd0_no_resp();
        test_cmd8_resp();
        test_cmd55_resp();
        test_bad_crc();
        test_reset_mid_send();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
